monkey_collision_latch: RTL and testbench

- Per-frame collision detector that sits directly upstream of the monkey movement/collision block.
- Observes the monkey sprite's drawing request, the in-sprite pixel offset, and the rope/ground drawing requests during raster scan.
- Accumulates which sprite edges touched which objects; at each startOfFrame presents stable collision_with_rope, collision_with_ground and HitEdgeCode for the whole following frame.

---
 rtl/monkey_collision_latch_if.sv | 45 ++++
 rtl/monkey_collision_latch.sv | 243 ++++++++++++++++++++++++
 tb/tb_monkey_collision_latch.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/monkey_collision_latch_if.sv
// -----------------------------------------------------------------------------
// monkey_collision_latch_if
//
// Purpose: groups the per-pixel raster inputs and the per-frame collision
// results exchanged between the raster pipeline and monkey_collision_latch.
//
// Signals:
//   startOfFrame          one-clock pulse at frame start
//   monkeyDR              monkey sprite drawing request for the current pixel
//   offsetX, offsetY      pixel offset inside the monkey sprite (11 bits each)
//   ropeDR                rope drawing request for the current pixel
//   groundDR              ground/platform drawing request for the current pixel
//   collision_with_rope   rope collision seen in the previous frame
//   collision_with_ground ground collision seen in the previous frame
//   HitEdgeCode           {left, top, right, bottom} edges touched last frame
//   collisionPulse        one-clock pulse when a collision newly appears
//
// Modports:
//   master  raster side: drives the pixel stream, observes the results
//   slave   collision latch: consumes the pixel stream, drives the results
// -----------------------------------------------------------------------------
interface monkey_collision_latch_if;
  logic        startOfFrame;
  logic        monkeyDR;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        ropeDR;
  logic        groundDR;
  logic        collision_with_rope;
  logic        collision_with_ground;
  logic [3:0]  HitEdgeCode;
  logic        collisionPulse;

  modport master (
    output startOfFrame, monkeyDR, offsetX, offsetY, ropeDR, groundDR,
    input  collision_with_rope, collision_with_ground, HitEdgeCode,
           collisionPulse
  );

  modport slave (
    input  startOfFrame, monkeyDR, offsetX, offsetY, ropeDR, groundDR,
    output collision_with_rope, collision_with_ground, HitEdgeCode,
           collisionPulse
  );
endinterface : monkey_collision_latch_if

// File: rtl/monkey_collision_latch.sv
// -----------------------------------------------------------------------------
// monkey_collision_latch
//
// Purpose: per-frame collision detector placed directly upstream of the monkey
// movement/collision block. During the raster scan it watches the monkey
// sprite drawing request together with the rope and ground drawing requests,
// counts overlapping pixels per object and records which sprite edges were
// involved. At every startOfFrame the accumulated result is latched, so the
// outputs describe frame N for the whole duration of frame N+1.
//
// Parameters:
//   SPRITE_W    monkey sprite width in pixels
//   SPRITE_H    monkey sprite height in pixels
//   EDGE_W      edge band thickness; offsets inside this band are edge hits
//   MIN_PIXELS  overlapping pixels per object per frame needed for a collision
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    monkey_collision_latch_if.slave (pixel stream in, results out)
//
// Optional feature (macro GROUND_COYOTE_EN):
//   When defined, a ground contact keeps collision_with_ground and its
//   HitEdgeCode bits asserted for one extra frame after contact is lost, which
//   hides single-frame flicker while walking across gaps in platforms. A
//   collisionPulse is not generated when contact returns within that frame.
//   When undefined, the ground flag strictly reflects the previous frame.
// -----------------------------------------------------------------------------
module monkey_collision_latch #(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int EDGE_W     = 3,
  parameter int MIN_PIXELS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  monkey_collision_latch_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [0:0] WAIT_SOF = 1'b0;  // idle until the first frame begins
  localparam logic [0:0] ACCUM    = 1'b1;  // accumulate and latch every frame

  // Thresholds sized to the offset buses so every comparison is width-matched.
  localparam logic [10:0] EDGE_LIM   = 11'(EDGE_W);
  localparam logic [10:0] RIGHT_LIM  = 11'(SPRITE_W - EDGE_W);
  localparam logic [10:0] BOTTOM_LIM = 11'(SPRITE_H - EDGE_W);

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] MIN_CNT = 12'(MIN_PIXELS);

  // ---------------------------------------------------------------------------
  // State and accumulators
  // ---------------------------------------------------------------------------
  logic [0:0]  state;

  logic [11:0] rope_cnt;
  logic [11:0] ground_cnt;
  logic [3:0]  rope_edges;
  logic [3:0]  ground_edges;

  // Latched per-frame results; the edge code is kept per object so the
  // ground part can be held independently when hold-over is enabled.
  logic        rope_flag;
  logic        ground_flag;
  logic [3:0]  rope_code;
  logic [3:0]  ground_code;
  logic        pulse;

  // ---------------------------------------------------------------------------
  // Per-pixel classification
  // ---------------------------------------------------------------------------
  logic [3:0]  pix_edges;   // {left, top, right, bottom}
  logic        rope_hit;
  logic        ground_hit;

  // NOTE: every signal driven from always_comb is given a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    pix_edges    = '0;
    pix_edges[3] = (bus.offsetX <  EDGE_LIM);
    pix_edges[2] = (bus.offsetY <  EDGE_LIM);
    pix_edges[1] = (bus.offsetX >= RIGHT_LIM);
    pix_edges[0] = (bus.offsetY >= BOTTOM_LIM);
  end

  // Offsets are only meaningful while the monkey is drawn, so the hit terms
  // gate everything downstream on monkeyDR.
  assign rope_hit   = bus.monkeyDR & bus.ropeDR;
  assign ground_hit = bus.monkeyDR & bus.groundDR;

  // ---------------------------------------------------------------------------
  // Accumulator next-state
  // ---------------------------------------------------------------------------
  // A startOfFrame clock opens a new frame in either state: the accumulators
  // restart from the pixel presented on that same clock, while the latch
  // (ACCUM only) consumes the values accumulated before it.
  logic        frame_start;
  logic        accum_en;
  logic        latch_now;
  logic [11:0] rope_cnt_nxt;
  logic [11:0] ground_cnt_nxt;
  logic [3:0]  rope_edges_nxt;
  logic [3:0]  ground_edges_nxt;

  assign frame_start = bus.startOfFrame;
  assign accum_en    = (state == ACCUM);
  assign latch_now   = accum_en & frame_start;

  always_comb begin
    rope_cnt_nxt     = rope_cnt;
    ground_cnt_nxt   = ground_cnt;
    rope_edges_nxt   = rope_edges;
    ground_edges_nxt = ground_edges;

    if (frame_start) begin
      rope_cnt_nxt     = rope_hit   ? 12'd1     : 12'd0;
      ground_cnt_nxt   = ground_hit ? 12'd1     : 12'd0;
      rope_edges_nxt   = rope_hit   ? pix_edges : 4'd0;
      ground_edges_nxt = ground_hit ? pix_edges : 4'd0;
    end else if (accum_en) begin
      if (rope_hit) begin
        // Saturate instead of wrapping so a long overlap never reads as small.
        if (rope_cnt != CNT_MAX) rope_cnt_nxt = rope_cnt + 12'd1;
        rope_edges_nxt = rope_edges | pix_edges;
      end
      if (ground_hit) begin
        if (ground_cnt != CNT_MAX) ground_cnt_nxt = ground_cnt + 12'd1;
        ground_edges_nxt = ground_edges | pix_edges;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame latch decisions
  // ---------------------------------------------------------------------------
  logic       rope_qual;
  logic       ground_qual;
  logic       ground_keep;       // ground flag value to present next frame
  logic [3:0] ground_code_nxt;   // ground-sourced edge bits for next frame
  logic       new_any;
  logic       old_any;

  assign rope_qual   = (rope_cnt   >= MIN_CNT);
  assign ground_qual = (ground_cnt >= MIN_CNT);

`ifdef GROUND_COYOTE_EN
  // Set by a qualified ground latch, cleared by the first unqualified one;
  // while set, one missing ground frame is bridged with the previous result.
  logic holdoff;

  always_ff @(posedge clk) begin
    if (reset) begin
      holdoff <= 1'b0;
    end else if (latch_now) begin
      holdoff <= ground_qual;
    end
  end

  always_comb begin
    ground_keep     = ground_qual | holdoff;
    ground_code_nxt = 4'd0;
    if (ground_qual) begin
      ground_code_nxt = ground_edges;
    end else if (holdoff) begin
      ground_code_nxt = ground_code;
    end
  end
`else
  always_comb begin
    ground_keep     = ground_qual;
    ground_code_nxt = ground_qual ? ground_edges : 4'd0;
  end
`endif

  // The pulse compares against the flags currently on the outputs, so a
  // bridged ground frame keeps old_any high and suppresses a re-fire.
  assign new_any = rope_qual | ground_keep;
  assign old_any = rope_flag | ground_flag;

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_SOF;
      rope_cnt     <= '0;
      ground_cnt   <= '0;
      rope_edges   <= '0;
      ground_edges <= '0;
      rope_flag    <= 1'b0;
      ground_flag  <= 1'b0;
      rope_code    <= '0;
      ground_code  <= '0;
      pulse        <= 1'b0;
    end else begin
      rope_cnt     <= rope_cnt_nxt;
      ground_cnt   <= ground_cnt_nxt;
      rope_edges   <= rope_edges_nxt;
      ground_edges <= ground_edges_nxt;
      pulse        <= 1'b0;

      case (state)
        WAIT_SOF: begin
          // The first frame boundary only arms the latch; the results loaded
          // here are all zero because nothing was accumulated before it.
          if (frame_start) begin
            state       <= ACCUM;
            rope_flag   <= 1'b0;
            ground_flag <= 1'b0;
            rope_code   <= '0;
            ground_code <= '0;
          end
        end

        ACCUM: begin
          if (latch_now) begin
            rope_flag   <= rope_qual;
            ground_flag <= ground_keep;
            rope_code   <= rope_qual ? rope_edges : 4'd0;
            ground_code <= ground_code_nxt;
            pulse       <= new_any & ~old_any;
          end
        end

        default: state <= WAIT_SOF;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.collision_with_rope   = rope_flag;
  assign bus.collision_with_ground = ground_flag;
  assign bus.HitEdgeCode           = rope_code | ground_code;
  assign bus.collisionPulse        = pulse;

endmodule : monkey_collision_latch

// File: tb/tb_monkey_collision_latch.sv
// -----------------------------------------------------------------------------
// tb_monkey_collision_latch
//
// Self-checking bench for monkey_collision_latch. Every clock is checked
// against a frame-level reference model (integer pixel counts per object and
// edge sets derived from the sprite geometry); the directed scenarios also
// check hand-derived constants. Honors GROUND_COYOTE_EN when defined.
// -----------------------------------------------------------------------------
module tb_monkey_collision_latch;

  localparam int SPR_W  = 32;
  localparam int SPR_H  = 32;
  localparam int EDGE   = 3;
  localparam int MINPIX = 2;
  localparam int SAT    = 4095;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  monkey_collision_latch_if bus ();

  monkey_collision_latch #(
    .SPRITE_W  (SPR_W),
    .SPRITE_H  (SPR_H),
    .EDGE_W    (EDGE),
    .MIN_PIXELS(MINPIX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int step  = 0;

  // ---------------- reference model (frame level) ----------------
  bit         m_running;      // a frame boundary has been seen since reset
  int         m_rope_n;       // rope overlap pixels in the current frame
  int         m_gnd_n;        // ground overlap pixels in the current frame
  logic [3:0] m_rope_set;     // edges touched by rope this frame
  logic [3:0] m_gnd_set;      // edges touched by ground this frame
  bit         m_bridge;       // ground contact may be bridged for one frame
  bit         e_rope;
  bit         e_gnd;
  logic [3:0] e_code_r;
  logic [3:0] e_code_g;
  bit         e_pulse;

  function automatic logic [3:0] edges_of(int x, int y);
    logic [3:0] e;
    e[3] = (x < EDGE);
    e[2] = (y < EDGE);
    e[1] = (x >= SPR_W - EDGE);
    e[0] = (y >= SPR_H - EDGE);
    return e;
  endfunction

  task automatic model_clear();
    m_running = 0; m_rope_n = 0; m_gnd_n = 0;
    m_rope_set = '0; m_gnd_set = '0; m_bridge = 0;
    e_rope = 0; e_gnd = 0; e_code_r = '0; e_code_g = '0; e_pulse = 0;
  endtask

  task automatic model_clock(bit sof, bit mdr, int x, int y, bit rdr, bit gdr);
    bit r = mdr && rdr;
    bit g = mdr && gdr;
    bit was_any;
    e_pulse = 0;
    if (sof) begin
      if (m_running) begin
        was_any  = e_rope || e_gnd;
        e_rope   = (m_rope_n >= MINPIX);
        e_code_r = e_rope ? m_rope_set : 4'd0;
`ifdef GROUND_COYOTE_EN
        if (m_gnd_n >= MINPIX) begin
          e_gnd = 1; e_code_g = m_gnd_set; m_bridge = 1;
        end else if (m_bridge) begin
          m_bridge = 0;            // previous ground result shown once more
        end else begin
          e_gnd = 0; e_code_g = '0;
        end
`else
        e_gnd    = (m_gnd_n >= MINPIX);
        e_code_g = e_gnd ? m_gnd_set : 4'd0;
`endif
        e_pulse  = (e_rope || e_gnd) && !was_any;
      end
      m_running  = 1;
      m_rope_n   = r ? 1 : 0;
      m_gnd_n    = g ? 1 : 0;
      m_rope_set = r ? edges_of(x, y) : 4'd0;
      m_gnd_set  = g ? edges_of(x, y) : 4'd0;
    end else if (m_running) begin
      if (r) begin
        m_rope_n   = (m_rope_n < SAT) ? m_rope_n + 1 : SAT;
        m_rope_set = m_rope_set | edges_of(x, y);
      end
      if (g) begin
        m_gnd_n   = (m_gnd_n < SAT) ? m_gnd_n + 1 : SAT;
        m_gnd_set = m_gnd_set | edges_of(x, y);
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
    end
  endtask

  task automatic check_model();
    check("rope_flag",   32'(bus.collision_with_rope),   32'(e_rope));
    check("ground_flag", 32'(bus.collision_with_ground), 32'(e_gnd));
    check("edge_code",   32'(bus.HitEdgeCode),           32'(e_code_r | e_code_g));
    check("pulse",       32'(bus.collisionPulse),        32'(e_pulse));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clock_step(bit sof, bit mdr, int x, int y, bit rdr, bit gdr);
    @(negedge clk);
    bus.startOfFrame = sof;
    bus.monkeyDR     = mdr;
    bus.offsetX      = 11'(x);
    bus.offsetY      = 11'(y);
    bus.ropeDR       = rdr;
    bus.groundDR     = gdr;
    @(posedge clk);
    step++;
    model_clock(sof, mdr, x, y, rdr, gdr);
    #1;
    check_model();
  endtask

  task automatic pix(int x, int y, bit r, bit g);
    clock_step(0, 1, x, y, r, g);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) clock_step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic sof();
    clock_step(1, 0, 0, 0, 0, 0);
  endtask

  // Two empty frames leave every flag and any ground hold-over cleared.
  task automatic flush();
    idle(2); sof(); idle(2); sof(); idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.startOfFrame = 0; bus.monkeyDR = 0; bus.ropeDR = 0; bus.groundDR = 0;
    @(posedge clk);
    step++;
    model_clear();
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    bus.startOfFrame = 0; bus.monkeyDR = 0; bus.ropeDR = 0; bus.groundDR = 0;
    bus.offsetX = '0; bus.offsetY = '0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();
    check("reset_flags", {bus.collision_with_rope, bus.collision_with_ground}, 0);

    // Pixels before the first frame boundary are ignored; first SOF latches 0.
    for (int i = 0; i < 3; i++) pix(10, 31, 1, 1);
    sof();
    check("first_sof_code", 32'(bus.HitEdgeCode), 0);
    check("first_sof_gnd", 32'(bus.collision_with_ground), 0);

    // Ground on the bottom edge.
    for (int i = 0; i < 5; i++) pix(10, 31, 0, 1);
    idle(2);
    sof();
    check("gnd_bottom_flag", 32'(bus.collision_with_ground), 1);
    check("gnd_bottom_code", 32'(bus.HitEdgeCode), 32'h1);
    check("gnd_bottom_pulse", 32'(bus.collisionPulse), 1);
    idle(1);
    check("gnd_pulse_one_clk", 32'(bus.collisionPulse), 0);

    // Rope at the top-left corner: one pixel is below threshold, two qualify.
    flush();
    pix(0, 0, 1, 0);
    sof();
    check("rope_single_flag", 32'(bus.collision_with_rope), 0);
    check("rope_single_code", 32'(bus.HitEdgeCode), 0);
    pix(0, 0, 1, 0); pix(0, 0, 1, 0);
    sof();
    check("rope_pair_flag", 32'(bus.collision_with_rope), 1);
    check("rope_pair_code", 32'(bus.HitEdgeCode), 32'hC);

    // Rope on the right edge plus ground on the top edge, repeated.
    flush();
    pix(31, 10, 1, 0); pix(31, 10, 1, 0);
    pix(10, 0, 0, 1);  pix(10, 0, 0, 1);
    sof();
    check("both_code", 32'(bus.HitEdgeCode), 32'h6);
    check("both_pulse", 32'(bus.collisionPulse), 1);
    pix(31, 10, 1, 0); pix(31, 10, 1, 0);
    pix(10, 0, 0, 1);  pix(10, 0, 0, 1);
    sof();
    check("repeat_code", 32'(bus.HitEdgeCode), 32'h6);
    check("repeat_no_pulse", 32'(bus.collisionPulse), 0);

    // Overlap pixel coincident with startOfFrame belongs to the new frame.
    flush();
    pix(10, 10, 1, 0);
    clock_step(1, 1, 10, 10, 1, 0);
    check("sof_pix_excluded", 32'(bus.collision_with_rope), 0);
    pix(10, 10, 1, 0);
    sof();
    check("sof_pix_counted", 32'(bus.collision_with_rope), 1);
    check("sof_pix_interior", 32'(bus.HitEdgeCode), 0);

    // Ground contact followed by two empty frames.
    flush();
    for (int i = 0; i < 3; i++) pix(10, 10, 0, 1);
    sof();
    check("coyote_f1", 32'(bus.collision_with_ground), 1);
    idle(3);
    sof();
`ifdef GROUND_COYOTE_EN
    check("coyote_f2", 32'(bus.collision_with_ground), 1);
`else
    check("coyote_f2", 32'(bus.collision_with_ground), 0);
`endif
    idle(3);
    sof();
    check("coyote_f3", 32'(bus.collision_with_ground), 0);

    // Saturation: 4097 pixels would wrap a 12-bit counter to 1.
    flush();
    for (int i = 0; i < 4097; i++) pix(10, 10, 0, 1);
    sof();
    check("sat_flag", 32'(bus.collision_with_ground), 1);

    // Reset mid-frame with flags set, then restart.
    pix(0, 31, 1, 1); pix(0, 31, 1, 1);
    do_reset();
    check("midreset_gnd", 32'(bus.collision_with_ground), 0);
    check("midreset_pulse", 32'(bus.collisionPulse), 0);
    pix(5, 5, 0, 1); pix(5, 5, 0, 1);
    sof();
    check("post_reset_sof", 32'(bus.collision_with_ground), 0);
    pix(5, 31, 0, 1); pix(5, 31, 0, 1);
    sof();
    check("post_reset_gnd", 32'(bus.collision_with_ground), 1);
    check("post_reset_pulse", 32'(bus.collisionPulse), 1);

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      int len = int'($urandom_range(4, 40));
      for (int c = 0; c < len; c++)
        clock_step(0, ($urandom % 3) != 0, int'($urandom_range(0, SPR_W - 1)),
                   int'($urandom_range(0, SPR_H - 1)),
                   ($urandom % 5) == 0, ($urandom % 6) == 0);
      clock_step(1, ($urandom % 4) == 0, int'($urandom_range(0, SPR_W - 1)),
                 int'($urandom_range(0, SPR_H - 1)),
                 ($urandom % 2) == 0, ($urandom % 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_monkey_collision_latch
